// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Multi-cycle restoring integer divider for DIV / DIVU. Produces
//            one quotient bit per clock and returns {remainder, quotient}
//            packed for HI/LO write-back.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous active-high reset
//            signed_div_i - 1 = signed (DIV), 0 = unsigned (DIVU)
//            opdata1_i    - dividend
//            opdata2_i    - divisor
//            start_i      - request, held high until ready_o is seen
//            annul_i      - abort current division (DIV_ANNUL_EN only)
//            result_o     - {remainder, quotient}
//            ready_o      - result_o valid
// Options  : define DIV_ANNUL_EN to add the annul_i flush port.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
`ifdef DIV_ANNUL_EN
    input  logic                 annul_i,
`endif
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam logic [1:0] c_div_free   = 2'd0;
    localparam logic [1:0] c_div_byzero = 2'd1;
    localparam logic [1:0] c_div_on     = 2'd2;
    localparam logic [1:0] c_div_end    = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_quo;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_divisor;
    logic               r_signed;
    logic               r_sign1;
    logic               r_sign2;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_annul;
    logic               w_divisor_zero;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

`ifdef DIV_ANNUL_EN
    assign w_annul = annul_i;
`else
    assign w_annul = 1'b0;
`endif

    assign w_divisor_zero = (opdata2_i == '0);

    // Magnitudes: in signed mode a negative operand is two's-complement negated.
    assign w_dvd_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_dvs_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Restoring step: the remainder is shifted left taking the next dividend
    // bit; the trial subtract is WIDTH+1 wide so its MSB is the borrow.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_divisor};

    // Quotient is negative when the operand signs differ; the remainder
    // follows the sign of the dividend.
    assign w_quo_fix = (r_signed && (r_sign1 ^ r_sign2)) ? -r_quo : r_quo;
    assign w_rem_fix = (r_signed && r_sign1) ? -r_rem : r_rem;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_div_free;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_div_free: begin
                if (start_i && !w_annul) begin
                    w_next_state = w_divisor_zero ? c_div_byzero : c_div_on;
                end
            end
            c_div_byzero: begin
                w_next_state = w_annul ? c_div_free : c_div_end;
            end
            c_div_on: begin
                if (w_annul) begin
                    w_next_state = c_div_free;
                end else if (r_cnt == c_cnt_last) begin
                    w_next_state = c_div_end;
                end
            end
            c_div_end: begin
                if (!start_i) begin
                    w_next_state = c_div_free;
                end
            end
            default: w_next_state = c_div_free;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_signed  <= 1'b0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                c_div_free: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                    if (start_i && !w_annul) begin
                        r_cnt <= '0;
                        if (!w_divisor_zero) begin
                            r_quo     <= w_dvd_mag;
                            r_divisor <= w_dvs_mag;
                            r_rem     <= '0;
                            r_signed  <= signed_div_i;
                            r_sign1   <= opdata1_i[WIDTH-1];
                            r_sign2   <= opdata2_i[WIDTH-1];
                        end
                    end
                end
                c_div_byzero: begin
                    r_result <= '0;
                    r_ready  <= !w_annul;
                end
                c_div_on: begin
                    if (w_annul) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_ready  <= 1'b1;
                    end else begin
                        if (!w_trial[WIDTH]) begin
                            r_rem <= w_trial[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_div_end: begin
                    if (!start_i) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule
`default_nettype wire
